// File: rtl/cl_mcl_pkg.sv
// Shared types and default sizing for the manycore link request path.
// The credit monitor in the AXI-Lite adapter sizes itself from the same constants.
package cl_mcl_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_e;

  localparam int default_fifo_width_lp  = 32;
  localparam int default_packet_width_lp = 128;
  localparam int default_out_credits_lp  = 16;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/bsg_mcl_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// Starts full; a return with no send while full saturates and latches overflow.
module bsg_mcl_credit_counter #(
  parameter int max_p   = 16,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               dec_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o
);

  // count tracks sends and returns; simultaneous events cancel out
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o    <= width_p'(max_p);
      overflow_o <= 1'b0;
    end else begin
      case ({dec_i, inc_i})
        2'b10: count_o <= count_o - width_p'(1);
        2'b01: begin
          if (count_o == width_p'(max_p)) begin
            overflow_o <= 1'b1;
          end else begin
            count_o <= count_o + width_p'(1);
          end
        end
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/bsg_mcl_fifos_to_packet_chk.sv
// Simulation checks for the FIFO-to-packet packer.
// A credit coming back while the pool is already full means the endpoint miscounted.
module bsg_mcl_fifos_to_packet_chk #(
  parameter int fifo_width_p   = 32,
  parameter int packet_width_p = 128
) (
  input logic clk_i,
  input logic reset_i,
  input logic credit_return_v_i,
  input logic send_i,
  input logic credits_full_i
);

  if (packet_width_p < fifo_width_p) begin : g_bad_width
    $error("packet_width_p must be at least fifo_width_p");
  end

  property p_return_has_outstanding;
    @(posedge clk_i) disable iff (reset_i)
      (credit_return_v_i && !send_i) |-> !credits_full_i;
  endproperty

  a_return_has_outstanding: assert property (p_return_has_outstanding)
    else $warning("credit returned with no packet outstanding");

endmodule

// File: rtl/bsg_mcl_fifos_to_packet.sv
// Packs consecutive tx FIFO words into one manycore request packet and
// issues it under credit-based flow control; collecting and sending never overlap.
module bsg_mcl_fifos_to_packet
  import cl_mcl_pkg::*;
#(
  parameter int fifo_width_p      = default_fifo_width_lp,
  parameter int packet_width_p    = default_packet_width_lp,
  parameter int max_out_credits_p = default_out_credits_lp
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      fifo_v_i,
  input  logic [fifo_width_p-1:0]   fifo_data_i,
  output logic                      fifo_ready_o,
  output logic                      packet_v_o,
  output logic [packet_width_p-1:0] packet_o,
  input  logic                      packet_ready_i,
  input  logic                      credit_return_v_i,
  output logic [fifo_width_p-1:0]   out_credits_o,
  output logic                      credit_overflow_o
);

  localparam int words_per_packet_lp = ceil_div(packet_width_p, fifo_width_p);
  localparam int cnt_width_lp        = (words_per_packet_lp > 1) ? $clog2(words_per_packet_lp) : 1;
  localparam int credit_width_lp     = $clog2(max_out_credits_p + 1);

  state_e                    state_r, state_n;
  logic [cnt_width_lp-1:0]   word_cnt_r;
  logic [packet_width_p-1:0] packet_r, packet_n;
  logic [credit_width_lp-1:0] credits;
  logic                      last_word;
  logic                      accept;
  logic                      send;

  assign last_word = (word_cnt_r == cnt_width_lp'(words_per_packet_lp - 1));
  assign accept    = fifo_v_i & fifo_ready_o;
  assign send      = packet_v_o & packet_ready_i;

  // next-state and handshake outputs
  always_comb begin
    state_n      = state_r;
    fifo_ready_o = 1'b0;
    packet_v_o   = 1'b0;
    case (state_r)
      COLLECT: begin
        fifo_ready_o = ~reset_i;
        if (fifo_v_i && !reset_i && last_word) begin
          state_n = SEND;
        end else begin
          state_n = COLLECT;
        end
      end
      SEND: begin
        packet_v_o = (credits != {credit_width_lp{1'b0}});
        if ((credits != {credit_width_lp{1'b0}}) && packet_ready_i) begin
          state_n = COLLECT;
        end else begin
          state_n = SEND;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // place the incoming word in its slot; bits past packet_width_p simply have no slot
  always_comb begin
    packet_n = packet_r;
    for (int p = 0; p < packet_width_p; p++) begin
      if (word_cnt_r == cnt_width_lp'(p / fifo_width_p)) begin
        packet_n[p] = fifo_data_i[p % fifo_width_p];
      end else begin
        packet_n[p] = packet_r[p];
      end
    end
  end

  // state, word index and packet buffer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= COLLECT;
      word_cnt_r <= {cnt_width_lp{1'b0}};
      packet_r   <= {packet_width_p{1'b0}};
    end else begin
      state_r <= state_n;
      if (accept) begin
        packet_r   <= packet_n;
        word_cnt_r <= last_word ? {cnt_width_lp{1'b0}} : word_cnt_r + cnt_width_lp'(1);
      end
    end
  end

  assign packet_o      = packet_r;
  assign out_credits_o = fifo_width_p'(credits);

  bsg_mcl_credit_counter #(
    .max_p  (max_out_credits_p),
    .width_p(credit_width_lp)
  ) u_credits (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .dec_i     (send),
    .inc_i     (credit_return_v_i),
    .count_o   (credits),
    .overflow_o(credit_overflow_o)
  );

  bsg_mcl_fifos_to_packet_chk #(
    .fifo_width_p  (fifo_width_p),
    .packet_width_p(packet_width_p)
  ) u_chk (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .credit_return_v_i(credit_return_v_i),
    .send_i           (send),
    .credits_full_i   (credits == credit_width_lp'(max_out_credits_p))
  );

endmodule

// File: tb/tb_bsg_mcl_fifos_to_packet.sv
// Three packers (default, 2 credits, 80-bit packet) driven by shared random words
// and per-instance credit returns, each checked against a word-list/credit model.
module tb_bsg_mcl_fifos_to_packet;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        fifo_v;
  logic [31:0] fifo_data;
  logic        packet_ready;
  logic        ret [3];

  logic         fr [3];
  logic         pv [3];
  logic [31:0]  oc [3];
  logic         ov [3];
  logic [127:0] pkt_a, pkt_b;
  logic [79:0]  pkt_c;
  logic [127:0] pk [3];

  assign pk[0] = pkt_a;
  assign pk[1] = pkt_b;
  assign pk[2] = {48'd0, pkt_c};

  always #5 clk = ~clk;

  bsg_mcl_fifos_to_packet dut_a (
    .clk_i(clk), .reset_i(reset_i), .fifo_v_i(fifo_v), .fifo_data_i(fifo_data),
    .fifo_ready_o(fr[0]), .packet_v_o(pv[0]), .packet_o(pkt_a), .packet_ready_i(packet_ready),
    .credit_return_v_i(ret[0]), .out_credits_o(oc[0]), .credit_overflow_o(ov[0]));

  bsg_mcl_fifos_to_packet #(.max_out_credits_p(2)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .fifo_v_i(fifo_v), .fifo_data_i(fifo_data),
    .fifo_ready_o(fr[1]), .packet_v_o(pv[1]), .packet_o(pkt_b), .packet_ready_i(packet_ready),
    .credit_return_v_i(ret[1]), .out_credits_o(oc[1]), .credit_overflow_o(ov[1]));

  bsg_mcl_fifos_to_packet #(.packet_width_p(80)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .fifo_v_i(fifo_v), .fifo_data_i(fifo_data),
    .fifo_ready_o(fr[2]), .packet_v_o(pv[2]), .packet_o(pkt_c), .packet_ready_i(packet_ready),
    .credit_return_v_i(ret[2]), .out_credits_o(oc[2]), .credit_overflow_o(ov[2]));

  int n_vec = 0;
  int n_bad = 0;

  // reference model: a packet is just the words received so far; credits are a plain integer
  int           m_max [3] = '{16, 2, 16};
  int           m_pw  [3] = '{128, 128, 80};
  int           m_wpp [3];
  logic [127:0] m_acc [3];
  logic [127:0] m_pkt [3];
  int           m_cnt [3];
  int           m_cred[3];
  bit           m_full[3];
  bit           m_ovf [3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_wpp[i]  = (m_pw[i] + 31) / 32;
      m_acc[i]  = 128'd0;
      m_pkt[i]  = 128'd0;
      m_cnt[i]  = 0;
      m_cred[i] = m_max[i];
      m_full[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  // pulse reset for one cycle, checking the outputs while it is held
  task automatic do_reset();
    reset_i = 1'b1;
    #4;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), 128'(fr[i]), 128'd0);
      chk($sformatf("rst_valid%0d", i), 128'(pv[i]), 128'd0);
      chk($sformatf("rst_credits%0d", i), 128'(oc[i]), 128'(m_max[i]));
      chk($sformatf("rst_ovf%0d", i), 128'(ov[i]), 128'd0);
    end
    model_reset();
    @(posedge clk); #1;
    reset_i = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic [2:0] rt);
    logic         snd;
    logic [127:0] mask;
    fifo_v       = v;
    fifo_data    = d;
    packet_ready = rdy;
    for (int i = 0; i < 3; i++) ret[i] = rt[i];
    #4;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready%0d", i), 128'(fr[i]), 128'(!m_full[i]));
      chk($sformatf("valid%0d", i), 128'(pv[i]), 128'(m_full[i] && m_cred[i] > 0));
      if (m_full[i] && m_cred[i] > 0) chk($sformatf("packet%0d", i), pk[i], m_pkt[i]);
      chk($sformatf("credits%0d", i), 128'(oc[i]), 128'(m_cred[i]));
      chk($sformatf("ovf%0d", i), 128'(ov[i]), 128'(m_ovf[i]));
    end
    for (int i = 0; i < 3; i++) begin
      mask = (m_pw[i] == 128) ? {128{1'b1}} : ((128'd1 << m_pw[i]) - 128'd1);
      snd  = m_full[i] && m_cred[i] > 0 && rdy;
      if (snd && !rt[i]) m_cred[i]--;
      else if (!snd && rt[i]) begin
        if (m_cred[i] == m_max[i]) m_ovf[i] = 1'b1;
        else m_cred[i]++;
      end
      if (snd) m_full[i] = 1'b0;
      else if (!m_full[i] && v) begin
        m_acc[i] = m_acc[i] | ((128'(d) << (32 * m_cnt[i])) & mask);
        m_cnt[i]++;
        if (m_cnt[i] == m_wpp[i]) begin
          m_pkt[i]  = m_acc[i];
          m_acc[i]  = 128'd0;
          m_cnt[i]  = 0;
          m_full[i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int cycles, input int ret_mod);
    logic [2:0] rt;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 3; i++)
        rt[i] = (ret_mod > 0) && ($urandom_range(ret_mod - 1) == 0) && (m_cred[i] < m_max[i]);
      step(($urandom_range(3) != 0), $urandom, $urandom_range(1), rt);
    end
  endtask

  logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    reset_i = 1'b1; fifo_v = 1'b0; fifo_data = 32'd0; packet_ready = 1'b0;
    for (int i = 0; i < 3; i++) ret[i] = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // four back-to-back words with the endpoint ready
    for (int k = 0; k < 4; k++) step(1'b1, words[k], 1'b1, 3'b000);
    chk("dflt_packet", pk[0], 128'h44444444_33333333_22222222_11111111);
    chk("dflt_valid", 128'(pv[0]), 128'd1);
    chk("odd_packet", pk[2], 128'h3333_22222222_11111111);
    step(1'b0, 32'd0, 1'b1, 3'b000);
    chk("dflt_credits", 128'(oc[0]), 128'd15);

    // endpoint stalls for ten cycles before accepting
    for (int k = 0; k < 4; k++) step(1'b1, $urandom, 1'b0, 3'b000);
    for (int k = 0; k < 10; k++) step(1'b1, $urandom, 1'b0, 3'b000);
    step(1'b1, $urandom, 1'b1, 3'b000);
    for (int k = 0; k < 6; k++) step(1'b1, $urandom, 1'b1, 3'b000);

    // reset part-way through a packet, then a fresh packet
    do_reset();
    step(1'b1, 32'hdead0001, 1'b0, 3'b000);
    step(1'b1, 32'hdead0002, 1'b0, 3'b000);
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, words[3-k], 1'b0, 3'b000);
    chk("reload_packet", pk[0], 128'h11111111_22222222_33333333_44444444);
    step(1'b0, 32'd0, 1'b1, 3'b000);

    // return while the pool is full on instance A only
    step(1'b0, 32'd0, 1'b0, 3'b001);
    step(1'b0, 32'd0, 1'b0, 3'b001);
    chk("ovf_sticky", 128'(ov[0]), 128'd1);

    rand_phase(200, 8);
    rand_phase(80, 0);
    rand_phase(150, 2);
    do_reset();
    rand_phase(120, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
